led_div_bank: RTL and testbench

- Parametrised, multi-channel, runtime-programmable clock-enable divider bank. It is the successor to the fixed Gowin CLKDIV chain that drives the board LEDs.
- All channels run in one clock domain (clkin). No derived clocks are generated; each channel produces a square wave plus a one-cycle tick.
- Optional cascade mode: channel i counts the ticks of channel i-1, which reproduces the chained-divider topology.
- Sits between the PLL output and the LED pins; also usable as a general slow-rate tick source.

---
 rtl/led_div_pkg.sv | 13 +
 rtl/led_div_channel.sv | 66 ++++++
 rtl/led_div_bank.sv | 53 +++++
 tb/tb_led_div_bank.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_div_pkg.sv
// Shared defaults and helpers for the LED clock-enable divider bank.
package led_div_pkg;

  localparam int          NUM_CH_DEF       = 6;
  localparam int          CNT_W_DEF        = 24;
  localparam int unsigned DEFAULT_HALF_DEF = 32'd5_999_999;

  // Index width for a channel select; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_div_channel.sv
// One divider channel: half-period counter, active/pending half-period
// registers, registered square wave and one-cycle tick.
module led_div_channel
  import led_div_pkg::*;
#(
  parameter int          CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             clkin,
  input  logic             resetn,
  input  logic             en,
  input  logic             src,
  input  logic             ld,
  input  logic [CNT_W-1:0] wr_data,
  output logic             div_out,
  output logic             tick,
  output logic             pend
);

  localparam logic [CNT_W-1:0] HP_RST = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hp;
  logic [CNT_W-1:0] hp_pend;

  // Count source events; toggle and retire any pending half-period at terminal.
  always_ff @(posedge clkin) begin
    if (!resetn) begin
      cnt     <= '0;
      hp      <= HP_RST;
      hp_pend <= HP_RST;
      pend    <= 1'b0;
      div_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (en && src) begin
        if (cnt == hp) begin
          cnt     <= '0;
          div_out <= ~div_out;
          tick    <= 1'b1;
          if (pend) begin
            hp   <= hp_pend;
            pend <= 1'b0;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      // A running channel defers the new value to its next terminal so the
      // current half-period is never cut short; an idle channel takes it now.
      // Placed last so a write landing on a terminal leaves pend set.
      if (ld) begin
        if (en) begin
          hp_pend <= wr_data;
          pend    <= 1'b1;
        end else begin
          hp   <= wr_data;
          cnt  <= '0;
          pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/led_div_bank.sv
// Multi-channel programmable clock-enable divider bank. All channels share
// clkin; optional cascade makes each channel count its predecessor's ticks.
module led_div_bank
  import led_div_pkg::*;
#(
  parameter int          NUM_CH       = NUM_CH_DEF,
  parameter int          CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF,
  parameter bit          CASCADE      = 1'b1
) (
  input  logic                            clkin,
  input  logic                            resetn,
  input  logic [NUM_CH-1:0]               en,
  input  logic                            wr_en,
  input  logic [clog2_min1(NUM_CH)-1:0]   wr_ch,
  input  logic [CNT_W-1:0]                wr_data,
  output logic [NUM_CH-1:0]               div_out,
  output logic [NUM_CH-1:0]               tick,
  output logic [NUM_CH-1:0]               pend
);

  localparam int WR_W = clog2_min1(NUM_CH);

  logic [NUM_CH-1:0] src;
  logic [NUM_CH-1:0] ld;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    if (i == 0 || !CASCADE) begin : g_src_free
      assign src[i] = 1'b1;
    end else begin : g_src_chain
      assign src[i] = tick[i-1];
    end

    // Out-of-range channel indices match no channel and are dropped.
    assign ld[i] = wr_en && (wr_ch == WR_W'(i));

    led_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clkin   (clkin),
      .resetn  (resetn),
      .en      (en[i]),
      .src     (src[i]),
      .ld      (ld[i]),
      .wr_data (wr_data),
      .div_out (div_out[i]),
      .tick    (tick[i]),
      .pend    (pend[i])
    );
  end

endmodule

// File: tb/tb_led_div_bank.sv
// Bench for led_div_bank: a free-running bank and a cascaded bank driven with
// identical stimulus, checked against directed expectations and a
// cycle-level behavioural model.
module tb_led_div_bank;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int DH = 3;

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] en;
  logic         wr_en;
  logic [1:0]   wr_ch;
  logic [W-1:0] wr_data;
  logic [N-1:0] div0, tick0, pend0;
  logic [N-1:0] div1, tick1, pend1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_div_bank #(.NUM_CH(N), .CNT_W(W), .DEFAULT_HALF(DH), .CASCADE(1'b0)) dut_free (
    .clkin(clk), .resetn(resetn), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_data(wr_data), .div_out(div0), .tick(tick0), .pend(pend0));

  led_div_bank #(.NUM_CH(N), .CNT_W(W), .DEFAULT_HALF(DH), .CASCADE(1'b1)) dut_casc (
    .clkin(clk), .resetn(resetn), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_data(wr_data), .div_out(div1), .tick(tick1), .pend(pend1));

  // Behavioural model; index [c][i], c=0 free-running bank, c=1 cascaded bank.
  int m_cnt [2][N];
  int m_hp  [2][N];
  int m_hpp [2][N];
  bit m_pend[2][N];
  bit m_div [2][N];
  bit m_tick[2][N];

  task automatic model_update();
    int o_cnt [2][N];
    int o_hp  [2][N];
    int o_hpp [2][N];
    bit o_pend[2][N];
    bit o_div [2][N];
    bit o_tick[2][N];
    bit s;
    o_cnt = m_cnt; o_hp = m_hp; o_hpp = m_hpp;
    o_pend = m_pend; o_div = m_div; o_tick = m_tick;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < N; i++) begin
        if (c == 0 || i == 0) s = 1'b1;
        else                  s = o_tick[c][i-1];
        m_tick[c][i] = 1'b0;
        if (!resetn) begin
          m_cnt[c][i] = 0; m_hp[c][i] = DH; m_hpp[c][i] = DH;
          m_pend[c][i] = 1'b0; m_div[c][i] = 1'b0;
        end else begin
          if (en[i] && s) begin
            if (o_cnt[c][i] == o_hp[c][i]) begin
              m_cnt[c][i]  = 0;
              m_div[c][i]  = !o_div[c][i];
              m_tick[c][i] = 1'b1;
              if (o_pend[c][i]) begin
                m_hp[c][i]   = o_hpp[c][i];
                m_pend[c][i] = 1'b0;
              end
            end else begin
              m_cnt[c][i] = o_cnt[c][i] + 1;
            end
          end
          if (wr_en && int'(wr_ch) == i) begin
            if (en[i]) begin
              m_hpp[c][i] = int'(wr_data); m_pend[c][i] = 1'b1;
            end else begin
              m_hp[c][i] = int'(wr_data); m_cnt[c][i] = 0; m_pend[c][i] = 1'b0;
            end
          end
        end
      end
    end
  endtask

  function automatic logic [N-1:0] vdiv(int c);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_div[c][i];
    return r;
  endfunction

  function automatic logic [N-1:0] vtick(int c);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_tick[c][i];
    return r;
  endfunction

  function automatic logic [N-1:0] vpend(int c);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_pend[c][i];
    return r;
  endfunction

  // Advance one edge; inputs are held stable across the edge, outputs read 1ns later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; en = '0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; en = 3'b111; wr_en = 1'b1; wr_ch = 2'd0; wr_data = 8'd9;
    step();
    wr_en = 1'b0;
    n_vec++; if (div0  !== 3'b000) begin n_err++; $display("FAIL reset_div0 got %b exp 000", div0); end
    n_vec++; if (tick0 !== 3'b000) begin n_err++; $display("FAIL reset_tick0 got %b exp 000", tick0); end
    n_vec++; if (pend0 !== 3'b000) begin n_err++; $display("FAIL reset_pend0 got %b exp 000", pend0); end
    n_vec++; if (div1  !== 3'b000) begin n_err++; $display("FAIL reset_div1 got %b exp 000", div1); end
    n_vec++; if (tick1 !== 3'b000) begin n_err++; $display("FAIL reset_tick1 got %b exp 000", tick1); end
    n_vec++; if (pend1 !== 3'b000) begin n_err++; $display("FAIL reset_pend1 got %b exp 000", pend1); end
  endtask

  task automatic test_basic();
    logic ed, et;
    do_reset();
    en = 3'b111;
    for (int k = 1; k <= 16; k++) begin
      step();
      ed = ((k / 4) % 2) == 1;
      et = (k % 4) == 0;
      n_vec++; if (div0 !== {N{ed}}) begin n_err++; $display("FAIL basic_div edge %0d got %b exp %b", k, div0, {N{ed}}); end
      n_vec++; if (tick0 !== {N{et}}) begin n_err++; $display("FAIL basic_tick edge %0d got %b exp %b", k, tick0, {N{et}}); end
    end
  endtask

  // Each channel ticks on every toggle, so ch1 halves span 4 ch0 ticks (16 cycles).
  task automatic test_cascade();
    int r1a = -1, r1b = -1, r2a = -1, r2b = -1;
    logic p1 = 1'b0, p2 = 1'b0;
    do_reset();
    en = 3'b111;
    for (int k = 1; k <= 260; k++) begin
      step();
      n_vec++; if (div1 !== vdiv(1)) begin n_err++; $display("FAIL casc_div edge %0d got %b exp %b", k, div1, vdiv(1)); end
      n_vec++; if (tick1 !== vtick(1)) begin n_err++; $display("FAIL casc_tick edge %0d got %b exp %b", k, tick1, vtick(1)); end
      if (div1[1] && !p1) begin if (r1a < 0) r1a = k; else if (r1b < 0) r1b = k; end
      if (div1[2] && !p2) begin if (r2a < 0) r2a = k; else if (r2b < 0) r2b = k; end
      p1 = div1[1]; p2 = div1[2];
    end
    n_vec++; if (r1a != 17)  begin n_err++; $display("FAIL casc_ch1_first_rise got %0d exp 17", r1a); end
    n_vec++; if (r1b != 49)  begin n_err++; $display("FAIL casc_ch1_second_rise got %0d exp 49", r1b); end
    n_vec++; if (r2a != 66)  begin n_err++; $display("FAIL casc_ch2_first_rise got %0d exp 66", r2a); end
    n_vec++; if (r2b != 194) begin n_err++; $display("FAIL casc_ch2_second_rise got %0d exp 194", r2b); end
  endtask

  task automatic test_pending_write();
    logic ed, et;
    do_reset();
    en = 3'b111;
    step();
    wr_en = 1'b1; wr_ch = 2'd0; wr_data = 8'd1;
    step();
    wr_en = 1'b0;
    n_vec++; if (pend0 !== 3'b001) begin n_err++; $display("FAIL pw_pend_set got %b exp 001", pend0); end
    step();
    n_vec++; if (pend0[0] !== 1'b1) begin n_err++; $display("FAIL pw_pend_hold got %b exp 1", pend0[0]); end
    n_vec++; if (div0[0] !== 1'b0) begin n_err++; $display("FAIL pw_div_hold got %b exp 0", div0[0]); end
    step();
    n_vec++; if (div0 !== 3'b111) begin n_err++; $display("FAIL pw_terminal_div got %b exp 111", div0); end
    n_vec++; if (tick0[0] !== 1'b1) begin n_err++; $display("FAIL pw_terminal_tick got %b exp 1", tick0[0]); end
    n_vec++; if (pend0[0] !== 1'b0) begin n_err++; $display("FAIL pw_pend_clear got %b exp 0", pend0[0]); end
    for (int k = 5; k <= 12; k++) begin
      step();
      ed = (((k - 4) / 2) % 2) == 0;
      et = (k % 2) == 0;
      n_vec++; if (div0[0] !== ed) begin n_err++; $display("FAIL pw_fast_div edge %0d got %b exp %b", k, div0[0], ed); end
      n_vec++; if (tick0[0] !== et) begin n_err++; $display("FAIL pw_fast_tick edge %0d got %b exp %b", k, tick0[0], et); end
    end
  endtask

  task automatic test_out_of_range();
    logic ed;
    do_reset();
    en = 3'b111; wr_en = 1'b1; wr_ch = 2'd3; wr_data = 8'd0;
    for (int k = 1; k <= 20; k++) begin
      step();
      ed = ((k / 4) % 2) == 1;
      n_vec++; if (div0 !== {N{ed}}) begin n_err++; $display("FAIL oor_div edge %0d got %b exp %b", k, div0, {N{ed}}); end
      n_vec++; if ((pend0 | pend1) !== 3'b000) begin n_err++; $display("FAIL oor_pend edge %0d got %b/%b exp 000", k, pend0, pend1); end
      n_vec++; if (div1[0] !== ed) begin n_err++; $display("FAIL oor_casc_div0 edge %0d got %b exp %b", k, div1[0], ed); end
    end
    wr_en = 1'b0; wr_ch = 2'd0;
  endtask

  task automatic test_disable();
    logic d;
    do_reset();
    en = 3'b111;
    step(); step();
    en = 3'b110;
    for (int k = 3; k <= 12; k++) begin
      step();
      n_vec++; if (div0[0] !== 1'b0 || tick0[0] !== 1'b0) begin n_err++; $display("FAIL dis_frozen edge %0d got div %b tick %b exp 0 0", k, div0[0], tick0[0]); end
      n_vec++; if (div0[1] !== (((k / 4) % 2) == 1)) begin n_err++; $display("FAIL dis_neighbor edge %0d got %b", k, div0[1]); end
    end
    en = 3'b111;
    step();
    n_vec++; if (div0[0] !== 1'b0) begin n_err++; $display("FAIL dis_resume_hold got %b exp 0", div0[0]); end
    step();
    n_vec++; if (div0[0] !== 1'b1 || tick0[0] !== 1'b1) begin n_err++; $display("FAIL dis_resume_toggle got div %b tick %b exp 1 1", div0[0], tick0[0]); end
    en = 3'b110; wr_en = 1'b1; wr_ch = 2'd0; wr_data = 8'd0;
    step();
    wr_en = 1'b0;
    n_vec++; if (pend0[0] !== 1'b0) begin n_err++; $display("FAIL dis_write_pend got %b exp 0", pend0[0]); end
    en = 3'b111;
    d = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      d = ~d;
      n_vec++; if (div0[0] !== d || tick0[0] !== 1'b1) begin n_err++; $display("FAIL dis_every_edge step %0d got div %b tick %b exp %b 1", k, div0[0], tick0[0], d); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 3'b111;
    step();
    wr_en = 1'b1; wr_ch = 2'd1; wr_data = 8'd1;
    step();
    wr_en = 1'b0;
    n_vec++; if (pend0[1] !== 1'b1) begin n_err++; $display("FAIL rm_pend_set got %b exp 1", pend0[1]); end
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    n_vec++; if ({div0, tick0, pend0} !== 9'b0) begin n_err++; $display("FAIL rm_cleared got %b exp 0", {div0, tick0, pend0}); end
    for (int k = 1; k <= 12; k++) begin
      step();
      n_vec++; if (div0[1] !== (((k / 4) % 2) == 1)) begin n_err++; $display("FAIL rm_resume edge %0d got %b", k, div0[1]); end
      n_vec++; if (pend0[1] !== 1'b0) begin n_err++; $display("FAIL rm_pend_gone edge %0d got %b exp 0", k, pend0[1]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      resetn  = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 7) != 0);
      wr_en   = ($urandom_range(0, 9) == 0);
      wr_ch   = 2'($urandom_range(0, 3));
      wr_data = 8'($urandom_range(0, 5));
      step();
      n_vec++; if (div0  !== vdiv(0))  begin n_err++; $display("FAIL rnd_div0 cyc %0d got %b exp %b", k, div0, vdiv(0)); end
      n_vec++; if (tick0 !== vtick(0)) begin n_err++; $display("FAIL rnd_tick0 cyc %0d got %b exp %b", k, tick0, vtick(0)); end
      n_vec++; if (pend0 !== vpend(0)) begin n_err++; $display("FAIL rnd_pend0 cyc %0d got %b exp %b", k, pend0, vpend(0)); end
      n_vec++; if (div1  !== vdiv(1))  begin n_err++; $display("FAIL rnd_div1 cyc %0d got %b exp %b", k, div1, vdiv(1)); end
      n_vec++; if (tick1 !== vtick(1)) begin n_err++; $display("FAIL rnd_tick1 cyc %0d got %b exp %b", k, tick1, vtick(1)); end
      n_vec++; if (pend1 !== vpend(1)) begin n_err++; $display("FAIL rnd_pend1 cyc %0d got %b exp %b", k, pend1, vpend(1)); end
    end
  endtask

  initial begin
    resetn = 1'b0; en = '0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    test_reset();
    test_basic();
    test_cascade();
    test_pending_write();
    test_out_of_range();
    test_disable();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
